// File: rtl/and_unit_rr_arbiter.sv
// and_unit_rr_arbiter: round-robin front end for one shared registered AND unit.
// Requesters hand over operands with valid/ready. At most one operation is issued
// per clock. A {vld,id} tag pipeline follows each operation through the unit so
// that its result is returned to the requester that issued it.
// Optional build macro AND_ARB_STATS_EN adds saturating per-requester grant
// counters (po_grant_cnt) and a synchronous clear input (pi_stats_clr).
module and_unit_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int OP_LAT  = 1,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        pi_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] pi_req_a,
  input  logic [NUM_REQ*DATA_W-1:0] pi_req_b,
  input  logic [NUM_REQ-1:0]        pi_req_mask,
  output logic [NUM_REQ-1:0]        po_req_ready,
  output logic [DATA_W-1:0]         po_unit_a,
  output logic [DATA_W-1:0]         po_unit_b,
  output logic                      po_unit_vld,
  input  logic [DATA_W-1:0]         pi_unit_c,
  output logic [NUM_REQ-1:0]        po_rsp_valid,
  output logic [DATA_W-1:0]         po_rsp_data,
  output logic                      po_busy
`ifdef AND_ARB_STATS_EN
  ,
  input  logic                      pi_stats_clr,
  output logic [NUM_REQ*16-1:0]     po_grant_cnt
`endif
);

  // One stage per unit latency edge, plus the stage that launches the response.
  localparam int STAGES = OP_LAT + 1;

  logic [ID_W-1:0]    ptr;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    idx;
  logic               accept;
  logic [DATA_W-1:0]  sel_a;
  logic [DATA_W-1:0]  sel_b;

  logic [STAGES-1:0]  tag_vld;
  logic [ID_W-1:0]    tag_id [STAGES];

  // Search eligible requesters from the pointer upward with wrap; the first hit wins.
  always_comb begin
    eligible = pi_req_valid & pi_req_mask;
    grant    = '0;
    grant_id = '0;
    idx      = '0;
    accept   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!accept && eligible[idx]) begin
        accept      = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
    // Nothing is granted while reset is held.
    if (!rst_n) begin
      grant  = '0;
      accept = 1'b0;
    end
  end

  assign po_req_ready = grant;

  // Operand mux for the granted requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a = pi_req_a[i*DATA_W +: DATA_W];
        sel_b = pi_req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  // Issue stage: register operands to the shared unit and advance the pointer past the winner.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr         <= '0;
      po_unit_a   <= '0;
      po_unit_b   <= '0;
      po_unit_vld <= 1'b0;
    end else begin
      po_unit_vld <= accept;
      if (accept) begin
        po_unit_a <= sel_a;
        po_unit_b <= sel_b;
        if (grant_id == ID_W'(NUM_REQ - 1)) ptr <= '0;
        else                                ptr <= grant_id + ID_W'(1);
      end
    end
  end

  // Tag pipeline: stage 0 captures the issue (or a bubble), later stages shift every clock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_vld <= '0;
      for (int s = 0; s < STAGES; s++) tag_id[s] <= '0;
    end else begin
      tag_vld   <= {tag_vld[STAGES-2:0], accept};
      tag_id[0] <= grant_id;
      for (int s = 1; s < STAGES; s++) tag_id[s] <= tag_id[s-1];
    end
  end

  // Response stage: the last tag stage lines up with the unit result on pi_unit_c.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      po_rsp_valid <= '0;
      po_rsp_data  <= '0;
      po_busy      <= 1'b0;
    end else begin
      po_busy <= |{tag_vld[STAGES-2:0], accept};
      if (tag_vld[STAGES-1]) begin
        po_rsp_valid <= NUM_REQ'(1) << tag_id[STAGES-1];
        po_rsp_data  <= pi_unit_c;
      end else begin
        po_rsp_valid <= '0;
      end
    end
  end

`ifdef AND_ARB_STATS_EN
  logic [15:0] grant_cnt [NUM_REQ];

  // Saturating per-requester grant counters; clear overrides a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n || pi_stats_clr) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && grant_cnt[i] != 16'hFFFF) grant_cnt[i] <= grant_cnt[i] + 16'd1;
      end
    end
  end

  // Flatten the counters onto the output bus.
  always_comb begin
    po_grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) po_grant_cnt[i*16 +: 16] = grant_cnt[i];
  end
`endif

endmodule

// File: tb/tb_and_unit_rr_arbiter.sv
// Bench for and_unit_rr_arbiter (NUM_REQ=4, DATA_W=8, OP_LAT=1) with a registered
// AND unit modelled in the bench and a transaction-level reference model.
module tb_and_unit_rr_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  valid, mask;
  logic [31:0] a_bus, b_bus;
  logic [3:0]  ready;
  logic [7:0]  unit_a, unit_b;
  logic        unit_vld;
  logic [7:0]  unit_c = 8'h00;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        busy;
`ifdef AND_ARB_STATS_EN
  logic        stats_clr;
  logic [63:0] grant_cnt;
`endif

  and_unit_rr_arbiter #(.NUM_REQ(4), .DATA_W(8), .OP_LAT(1), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .pi_req_valid(valid), .pi_req_a(a_bus), .pi_req_b(b_bus), .pi_req_mask(mask),
    .po_req_ready(ready), .po_unit_a(unit_a), .po_unit_b(unit_b), .po_unit_vld(unit_vld),
    .pi_unit_c(unit_c), .po_rsp_valid(rsp_valid), .po_rsp_data(rsp_data), .po_busy(busy)
`ifdef AND_ARB_STATS_EN
    , .pi_stats_clr(stats_clr), .po_grant_cnt(grant_cnt)
`endif
  );

  // Shared AND unit, one clock of latency.
  always @(posedge clk) unit_c <= unit_a & unit_b;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input logic [3:0] m, input int p);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (p + k) % 4;
      if (v[i] && m[i]) return i;
    end
    return -1;
  endfunction

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference model: pending responses as a queue of {requester, result, due edge}.
  typedef struct { int id; logic [7:0] data; int due; } rsp_t;
  rsp_t       q[$];
  int         cyc = 0;
  int         m_ptr = 0;
  logic [7:0] m_a = 8'h00, m_b = 8'h00, m_rsp_d = 8'h00;
  logic       m_vld = 1'b0, m_busy = 1'b0;
  logic [3:0] m_rsp_v = 4'h0;
  bit         chk_en = 1'b0;

  always @(posedge clk) begin
    int   g;
    rsp_t r;
    cyc++;
    if (!rst_n) begin
      m_ptr = 0; m_a = 8'h00; m_b = 8'h00; m_vld = 1'b0;
      q.delete();
      m_rsp_v = 4'h0; m_rsp_d = 8'h00; m_busy = 1'b0;
      chk_en = 1'b1;
    end else begin
      g = pick(valid, mask, m_ptr);
      if (q.size() > 0 && q[0].due == cyc) begin
        m_rsp_v = 4'(1 << q[0].id);
        m_rsp_d = q[0].data;
        void'(q.pop_front());
      end else begin
        m_rsp_v = 4'h0;
      end
      if (g >= 0) begin
        m_a    = a_bus[g*8 +: 8];
        m_b    = b_bus[g*8 +: 8];
        m_vld  = 1'b1;
        m_ptr  = (g + 1) % 4;
        r.id   = g;
        r.data = m_a & m_b;
        r.due  = cyc + 2;
        q.push_back(r);
      end else begin
        m_vld = 1'b0;
      end
      m_busy = (q.size() != 0);
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [3:0] exp_rdy;
    int g;
    if (chk_en) begin
      g = pick(valid, mask, m_ptr);
      exp_rdy = (rst_n && g >= 0) ? 4'(1 << g) : 4'h0;
      check("m_ready",     ready,     exp_rdy);
      check("m_unit_a",    unit_a,    m_a);
      check("m_unit_b",    unit_b,    m_b);
      check("m_unit_vld",  unit_vld,  m_vld);
      check("m_rsp_valid", rsp_valid, m_rsp_v);
      check("m_rsp_data",  rsp_data,  m_rsp_d);
      check("m_busy",      busy,      m_busy);
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic probe();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; valid = 4'h0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int gseq[$];
    int rids[$];
    int rdat[$];
    int exp_g2[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int exp_d2[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22, 8'h33, 8'h44};
    int exp_g3[6] = '{0, 1, 3, 0, 1, 3};
    int exp_d3[6] = '{8'h11, 8'h22, 8'h44, 8'h11, 8'h22, 8'h44};

    rst_n = 1'b0; valid = 4'h0; mask = 4'hF; a_bus = '0; b_bus = '0;
`ifdef AND_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    step(); step();
    probe();
    check("rst_ready", ready, 4'h0);
    check("rst_unit_vld", unit_vld, 1'b0);
    check("rst_rsp_valid", rsp_valid, 4'h0);
    check("rst_busy", busy, 1'b0);
    step();

    // Single requester
    rst_n = 1'b1; valid = 4'b0001; a_bus = 32'h0000_00F0; b_bus = 32'h0000_003C;
    probe(); check("t1_ready", ready, 4'b0001);
    step(); valid = 4'h0;
    probe();
    check("t1_unit_a", unit_a, 8'hF0);
    check("t1_unit_b", unit_b, 8'h3C);
    check("t1_unit_vld", unit_vld, 1'b1);
    check("t1_busy", busy, 1'b1);
    step(); probe(); check("t1_rsp_early", rsp_valid, 4'h0);
    step(); probe();
    check("t1_rsp_valid", rsp_valid, 4'b0001);
    check("t1_rsp_data", rsp_data, 8'h30);
    check("t1_busy_idle", busy, 1'b0);
    step(); probe(); check("t1_rsp_one_cycle", rsp_valid, 4'h0);
    step();

    // All four valid: strict rotation
    do_reset();
    mask = 4'hF; valid = 4'hF; a_bus = 32'hFFFF_FFFF; b_bus = 32'h4433_2211;
    for (int i = 0; i < 11; i++) begin
      if (i == 8) valid = 4'h0;
      probe();
      if (ready != 4'h0) gseq.push_back(oh_idx(ready));
      if (rsp_valid != 4'h0) begin rids.push_back(oh_idx(rsp_valid)); rdat.push_back(int'(rsp_data)); end
      step();
    end
    check("t2_grant_count", gseq.size(), 8);
    check("t2_rsp_count", rids.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check("t2_grant", (i < gseq.size()) ? gseq[i] : -1, exp_g2[i]);
      check("t2_rsp_id", (i < rids.size()) ? rids[i] : -1, exp_g2[i]);
      check("t2_rsp_data", (i < rdat.size()) ? rdat[i] : -1, exp_d2[i]);
    end

    // Masked requester 2
    gseq.delete(); rids.delete(); rdat.delete();
    do_reset();
    mask = 4'b1011; valid = 4'hF;
    for (int i = 0; i < 9; i++) begin
      if (i == 6) valid = 4'h0;
      probe();
      if (ready != 4'h0) gseq.push_back(oh_idx(ready));
      if (rsp_valid != 4'h0) begin rids.push_back(oh_idx(rsp_valid)); rdat.push_back(int'(rsp_data)); end
      step();
    end
    check("t3_grant_count", gseq.size(), 6);
    check("t3_rsp_count", rids.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check("t3_grant", (i < gseq.size()) ? gseq[i] : -1, exp_g3[i]);
      check("t3_rsp_id", (i < rids.size()) ? rids[i] : -1, exp_g3[i]);
      check("t3_rsp_data", (i < rdat.size()) ? rdat[i] : -1, exp_d3[i]);
    end

    // Pointer fairness
    do_reset();
    mask = 4'hF;
    valid = 4'b1000; probe(); check("t4_grant3", ready, 4'b1000); step();
    valid = 4'b0010; probe(); check("t4_grant1", ready, 4'b0010); step();
    valid = 4'b0101; probe(); check("t4_grant2_first", ready, 4'b0100); step();
    probe(); check("t4_grant0_next", ready, 4'b0001); step();
    valid = 4'h0; step(); step(); step();

    // Reset mid-flight
    do_reset();
    valid = 4'b0010; probe(); check("t5_accept", ready, 4'b0010); step();
    rst_n = 1'b0; probe(); check("t5_ready_in_rst", ready, 4'h0); step();
    rst_n = 1'b1; valid = 4'h0;
    probe();
    check("t5_unit_a", unit_a, 8'h00);
    check("t5_unit_vld", unit_vld, 1'b0);
    check("t5_busy", busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("t5_no_rsp", rsp_valid, 4'h0);
      step(); probe();
    end
    step();
    valid = 4'b0101; probe(); check("t5_ptr_restart", ready, 4'b0001); step();
    valid = 4'h0; step(); step(); step();

`ifdef AND_ARB_STATS_EN
    do_reset();
    probe(); check("st_reset", grant_cnt, 32'h0);
    step();
    valid = 4'b0001; step(); step(); valid = 4'h0;
    probe(); check("st_cnt0", grant_cnt[15:0], 16'd2);
    step();
    valid = 4'b0001; stats_clr = 1'b1; step(); stats_clr = 1'b0; valid = 4'h0;
    probe(); check("st_clr_wins", grant_cnt[15:0], 16'd0);
    step(); step(); step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/and_unit_rr_arbiter.md
Name: and_unit_rr_arbiter

Overview:
Round-robin arbiter that shares one registered 8-bit bitwise-AND unit (operands a/b in, result c out, fixed OP_LAT clock latency) among NUM_REQ requesters. Each requester presents operands with a valid/ready handshake. The block issues at most one operation per clock to the shared unit, tracks in-flight operations with a tag pipeline, and routes each result back to the originating requester. It sits between the client logic and the single AND datapath instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, operand/result width; must match the shared unit
OP_LAT, 1, clock edges from operands applied at the unit to pi_unit_c valid (1..4)
ID_W, 2, requester index width = clog2(NUM_REQ)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
pi_req_valid  input  NUM_REQ  per-requester request valid
pi_req_a  input  NUM_REQ*DATA_W  operand a, requester i at [i*DATA_W +: DATA_W]
pi_req_b  input  NUM_REQ*DATA_W  operand b, same packing
pi_req_mask  input  NUM_REQ  1 = requester enabled for arbitration; 0 = never granted
po_req_ready  output  NUM_REQ  one-hot grant/accept strobe (combinational)
po_unit_a  output  DATA_W  operand a to shared unit (registered)
po_unit_b  output  DATA_W  operand b to shared unit (registered)
po_unit_vld  output  1  operands on po_unit_a/b are a live issue (registered)
pi_unit_c  input  DATA_W  result from shared unit
po_rsp_valid  output  NUM_REQ  one-hot, one-cycle response strobe (registered)
po_rsp_data  output  DATA_W  result for the strobed requester (registered)
po_busy  output  1  1 while any operation is in flight (registered)

Behaviour:
- Reset (rst_n low at a rising edge): RR pointer = 0; po_unit_a/b = 0; po_unit_vld = 0; tag pipeline cleared; po_rsp_valid = 0; po_rsp_data = 0; po_busy = 0. Reset mid-operation discards all in-flight ops, with no responses produced. po_req_ready = 0 while rst_n low.
- Arbitration (combinational): eligible[i] = pi_req_valid[i] & pi_req_mask[i]. Search eligible starting at the RR pointer, ascending with wrap. The first hit i gets po_req_ready[i] = 1; all other bits 0. No eligible requester: po_req_ready = 0.
- Accept = valid & ready for the granted i at a rising edge. At that edge:
  - po_unit_a/b <= operands of i; po_unit_vld <= 1;
  - pointer <= (i+1) mod NUM_REQ;
  - the tag pipeline stage 0 <= {1, i}.
- No accept: po_unit_vld <= 0; po_unit_a/b hold; pointer holds.
- Tag pipeline: OP_LAT+1 stages of {vld, id}, shifting every clock. A bubble enters when there is no accept.
- Response: when the last stage holds vld = 1, the same edge sets po_rsp_valid <= onehot(id) and po_rsp_data <= pi_unit_c. Otherwise po_rsp_valid <= 0 and po_rsp_data holds.
- Latency: the accept edge is E0. po_rsp_valid is high for exactly the one cycle following edge E(OP_LAT+1). With OP_LAT=1, that is 2 edges after accept.
- Throughput: 1 op/clock sustained. Responses return in accept order; there is no response backpressure.
- po_busy = OR of all pipeline vld bits after update (registered).
- Masked requester with valid high: never granted, no deadlock for others.
- A single continuous requester is granted every cycle. All requesters continuously valid gives a strict rotation 0,1,2,3,0,…
- Changing pi_req_mask while ops are in flight does not affect responses already issued.

Optional Feature:
Macro AND_ARB_STATS_EN.
- Defined: adds output po_grant_cnt, width NUM_REQ*16. Per-requester 16-bit grant counters increment on each accept of that requester and saturate at 16'hFFFF. Reset clears them to 0. Input pi_stats_clr (1 bit, synchronous) clears all counters; clear wins over a same-cycle increment.
- Undefined: neither port exists, and there is no counter logic.

Test Plan:
- Single requester: reset, mask=4'hF, req0 valid with a=8'hF0, b=8'h3C for one accept → ready[0]=1 that cycle; po_unit_a=8'hF0, po_unit_b=8'h3C, vld=1 next cycle; rsp_valid=4'b0001 with rsp_data=8'h30, 2 edges after accept (OP_LAT=1).
- All four valid for 8 cycles with distinct operands (a=8'hFF, b=8'h11*(i+1)) → grants 0,1,2,3,0,1,2,3. Back-to-back responses in the same order with data 8'h11, 8'h22, 8'h33, 8'h44.
- Mask: mask=4'b1011, all valid → grants rotate 0,1,3,0,1,3. Requester 2 never ready, no response on bit 2.
- Pointer fairness: req3 then req1 accepted, then req0 and req2 valid together → req2 granted first (pointer=2), then req0.
- Reset mid-flight: accept req1, assert rst_n=0 the next cycle for 1 cycle → no rsp_valid ever for that op; all outputs 0; pointer restarts at 0.
- With AND_ARB_STATS_EN: preload req0 to 65535 grants (force or long run), then one more accept → counter stays 16'hFFFF. pi_stats_clr together with an accept → counter reads 0.
